// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side character buffer placed after character_recovery. Every
// completed character (good, framing error or parity error) is written with
// its two error flags into a small first-word-fall-through FIFO. The host
// drains it over a valid/ready handshake. A sticky flag records dropped
// characters. An optional idle timer lets the host drain partial bursts.
//
// Optional feature macro: UART_RX_FIFO_TIMEOUT_EN
//   defined   -> idle counter present, timeout_o driven by it
//   undefined -> no counter, timeout_o tied to 0
//
// Ports:
//   clk             in   clock
//   rst             in   synchronous, active-high reset
//   char_i          in   [DATA_BITS] character from the recovery stage
//   valid_i         in   strobe: good character
//   frame_error_i   in   strobe: framing error
//   parity_error_i  in   strobe: parity error
//   data_o          out  [DATA_BITS] head-of-FIFO character
//   frame_error_o   out  head entry framing-error flag
//   parity_error_o  out  head entry parity-error flag
//   valid_o         out  FIFO non-empty, head entry presented
//   ready_i         in   consumer takes the head when valid_o && ready_i
//   count_o         out  [$clog2(DEPTH)+1] occupancy, 0..DEPTH
//   overrun_o       out  sticky: a character was dropped
//   clear_overrun_i in   clears overrun_o (a new overrun in the same cycle wins)
//   timeout_o       out  receive-idle timeout
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DATA_BITS     = 8,
  parameter int DEPTH         = 16,
  parameter int OVERSAMPLING  = 16,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_BITS-1:0]       char_i,
  input  logic                       valid_i,
  input  logic                       frame_error_i,
  input  logic                       parity_error_i,
  output logic [DATA_BITS-1:0]       data_o,
  output logic                       frame_error_o,
  output logic                       parity_error_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overrun_o,
  input  logic                       clear_overrun_i,
  output logic                       timeout_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_BITS + 2;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  // Elaboration-time sanity checks on the configuration.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
  end
  if (OVERSAMPLING < 1 || TIMEOUT_CHARS < 1) begin : g_bad_timeout_cfg
    $error("uart_rx_fifo: OVERSAMPLING and TIMEOUT_CHARS must be >= 1");
  end

  // Entry layout: {frame_error, parity_error, character}
  logic [EW-1:0]  mem_q [DEPTH];
  logic [EW-1:0]  head;

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic           overrun_q, overrun_d;

  logic           wr, rd, empty, full, accept, drop;

  always_comb begin
    wr     = valid_i | frame_error_i | parity_error_i;
    empty  = (wr_ptr_q == rd_ptr_q);
    // Wrap bits differ and index bits match: writer is a full lap ahead.
    full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
             (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rd     = !empty && ready_i;
    // A read in the same cycle frees the slot, so a write into a full FIFO
    // is still accepted then; it lands in the slot the head is leaving.
    accept = wr && (!full || rd);
    drop   = wr && full && !rd;

    wr_ptr_d  = accept ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d  = rd     ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clear_overrun_i) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {frame_error_i, parity_error_i, char_i};
    end
  end

  assign head           = mem_q[rd_ptr_q[AW-1:0]];
  assign data_o         = head[DATA_BITS-1:0];
  assign parity_error_o = head[DATA_BITS];
  assign frame_error_o  = head[DATA_BITS+1];
  assign valid_o        = !empty;
  assign count_o        = wr_ptr_q - rd_ptr_q;
  assign overrun_o      = overrun_q;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int TO_LIMIT = OVERSAMPLING * 10 * TIMEOUT_CHARS;
  localparam int TW       = $clog2(TO_LIMIT) + 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TO_LIMIT);
  localparam logic [TW-1:0] TO_ONE = TW'(1);

  logic [TW-1:0] idle_q, idle_d;

  // Counts cycles with buffered data but no traffic in either direction;
  // holds at the limit so timeout_o stays up until something happens.
  always_comb begin
    idle_d = idle_q;
    if (wr || rd || empty) begin
      idle_d = '0;
    end else if (idle_q != TO_MAX) begin
      idle_d = idle_q + TO_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

  assign timeout_o = (idle_q == TO_MAX) && !empty;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DATA_BITS = 8;
  localparam int DEPTH     = 16;
  localparam int PW        = $clog2(DEPTH) + 1;
  localparam int TO_LIMIT  = 16 * 10 * 4;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic [DATA_BITS-1:0] char_i;
  logic                 valid_i, frame_error_i, parity_error_i;
  logic [DATA_BITS-1:0] data_o;
  logic                 frame_error_o, parity_error_o, valid_o;
  logic                 ready_i;
  logic [PW-1:0]        count_o;
  logic                 overrun_o, clear_overrun_i, timeout_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a queue of {frame, parity, char} entries, a sticky bit,
  // and the cycle index of the most recent write/read/reset.
  logic [DATA_BITS+1:0] mq[$];
  bit                   m_ovr;
  int                   cyc;
  int                   last_evt;

  uart_rx_fifo #(
    .DATA_BITS(DATA_BITS), .DEPTH(DEPTH), .OVERSAMPLING(16), .TIMEOUT_CHARS(4)
  ) dut (
    .clk(clk), .rst(rst), .char_i(char_i), .valid_i(valid_i),
    .frame_error_i(frame_error_i), .parity_error_i(parity_error_i),
    .data_o(data_o), .frame_error_o(frame_error_o),
    .parity_error_o(parity_error_o), .valid_o(valid_o), .ready_i(ready_i),
    .count_o(count_o), .overrun_o(overrun_o),
    .clear_overrun_i(clear_overrun_i), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, advance the model, and return 1 time unit
  // after the clock edge so outputs can be sampled.
  task automatic tick(input bit w, input bit fe, input bit pe,
                      input logic [DATA_BITS-1:0] ch, input bit rdy,
                      input bit clr, input bit r);
    bit mw, mrd;
    valid_i = w; frame_error_i = fe; parity_error_i = pe; char_i = ch;
    ready_i = rdy; clear_overrun_i = clr; rst = r;
    mw  = w | fe | pe;
    mrd = (mq.size() > 0) && rdy;
    if (r) begin
      mq.delete();
      m_ovr    = 1'b0;
      last_evt = cyc + 1;
    end else begin
      if (mw || mrd) last_evt = cyc + 1;
      if (mw && mq.size() == DEPTH && !mrd) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      if (mrd) void'(mq.pop_front());
      if (mw && mq.size() < DEPTH) mq.push_back({fe, pe, ch});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input bit rdy);
    tick(0, 0, 0, '0, rdy, 0, 0);
  endtask

  task automatic test_reset;
    tick(0, 0, 0, '0, 0, 0, 1);
    tick(0, 0, 0, '0, 0, 0, 1);
    idle(0);
    n_checks++;
    if (valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_checks++;
    if (count_o !== '0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
    n_checks++;
    if (overrun_o !== 1'b0) begin n_errors++; $display("FAIL reset_overrun: got %b want 0", overrun_o); end
    n_checks++;
    if (timeout_o !== 1'b0) begin n_errors++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
  endtask

  task automatic test_single;
    tick(1, 0, 0, 8'hA5, 0, 0, 0);
    n_checks++;
    if ({valid_o, data_o, frame_error_o, parity_error_o} !== {1'b1, 8'hA5, 2'b00}) begin
      n_errors++;
      $display("FAIL single_head: got v=%b d=%h f=%b p=%b want v=1 d=a5 f=0 p=0",
               valid_o, data_o, frame_error_o, parity_error_o);
    end
    n_checks++;
    if (count_o !== PW'(1)) begin n_errors++; $display("FAIL single_count: got %0d want 1", count_o); end
    idle(1);
    n_checks++;
    if (valid_o !== 1'b0 || count_o !== '0) begin
      n_errors++; $display("FAIL single_drain: got v=%b cnt=%0d want v=0 cnt=0", valid_o, count_o);
    end
  endtask

  task automatic test_flags;
    logic [7:0] exp_d [5] = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h7F};
    logic [1:0] exp_f [5] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01};
    tick(1, 0, 0, 8'h01, 0, 0, 0);
    tick(1, 0, 0, 8'h02, 0, 0, 0);
    tick(1, 0, 0, 8'h03, 0, 0, 0);
    tick(0, 1, 0, 8'h00, 0, 0, 0);
    tick(0, 0, 1, 8'h7F, 0, 0, 0);
    n_checks++;
    if (count_o !== PW'(5)) begin n_errors++; $display("FAIL flags_count: got %0d want 5", count_o); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({valid_o, data_o, frame_error_o, parity_error_o} !== {1'b1, exp_d[i], exp_f[i]}) begin
        n_errors++;
        $display("FAIL flags_entry%0d: got v=%b d=%h f=%b p=%b want v=1 d=%h fp=%b",
                 i, valid_o, data_o, frame_error_o, parity_error_o, exp_d[i], exp_f[i]);
      end
      idle(1);
    end
    n_checks++;
    if (valid_o !== 1'b0) begin n_errors++; $display("FAIL flags_empty: got %b want 0", valid_o); end
  endtask

  task automatic test_overrun;
    for (int i = 0; i < 16; i++) tick(1, 0, 0, 8'(i), 0, 0, 0);
    n_checks++;
    if (overrun_o !== 1'b0) begin n_errors++; $display("FAIL ovr_pre: got %b want 0", overrun_o); end
    tick(1, 0, 0, 8'hFF, 0, 0, 0);
    n_checks++;
    if (count_o !== PW'(16)) begin n_errors++; $display("FAIL ovr_count: got %0d want 16", count_o); end
    n_checks++;
    if (overrun_o !== 1'b1) begin n_errors++; $display("FAIL ovr_set: got %b want 1", overrun_o); end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (valid_o !== 1'b1 || data_o !== 8'(i)) begin
        n_errors++; $display("FAIL ovr_drain%0d: got v=%b d=%h want v=1 d=%h", i, valid_o, data_o, 8'(i));
      end
      idle(1);
    end
    n_checks++;
    if (valid_o !== 1'b0 || overrun_o !== 1'b1) begin
      n_errors++; $display("FAIL ovr_after_drain: got v=%b ovr=%b want v=0 ovr=1", valid_o, overrun_o);
    end
    tick(0, 0, 0, '0, 0, 1, 0);
    n_checks++;
    if (overrun_o !== 1'b0) begin n_errors++; $display("FAIL ovr_clear: got %b want 0", overrun_o); end
  endtask

  task automatic test_full_simul;
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) tick(1, 0, 0, 8'h80 + 8'(i), 0, 0, 0);
    tick(1, 0, 0, 8'h55, 1, 0, 0);
    n_checks++;
    if (count_o !== PW'(16)) begin n_errors++; $display("FAIL simul_count: got %0d want 16", count_o); end
    n_checks++;
    if (overrun_o !== 1'b0) begin n_errors++; $display("FAIL simul_overrun: got %b want 0", overrun_o); end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 8'h81 + 8'(i) : 8'h55;
      n_checks++;
      if (valid_o !== 1'b1 || data_o !== exp) begin
        n_errors++; $display("FAIL simul_drain%0d: got v=%b d=%h want v=1 d=%h", i, valid_o, data_o, exp);
      end
      idle(1);
    end
  endtask

  task automatic test_wrap_random;
    bit w, fe, pe, rdy, clr;
    bit exp_to;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        tick(1, 0, 0, 8'hEE, 1, 0, 1);
        n_checks++;
        if (valid_o !== 1'b0 || count_o !== '0) begin
          n_errors++; $display("FAIL mid_reset: got v=%b cnt=%0d want v=0 cnt=0", valid_o, count_o);
        end
        continue;
      end
      w   = ($urandom_range(0, 99) < 55);
      fe  = ($urandom_range(0, 99) < 8);
      pe  = ($urandom_range(0, 99) < 8);
      rdy = ($urandom_range(0, 99) < ((i % 100) < 50 ? 20 : 70));
      clr = ($urandom_range(0, 99) < 5);
      tick(w, fe, pe, 8'($urandom), rdy, clr, 0);
      exp_to = TO_EN && (mq.size() > 0) && (cyc - last_evt >= TO_LIMIT);
      n_checks++;
      if (valid_o !== (mq.size() > 0) || count_o !== PW'(mq.size()) ||
          overrun_o !== m_ovr || timeout_o !== exp_to) begin
        n_errors++;
        $display("FAIL rand%0d_status: got v=%b cnt=%0d ovr=%b to=%b want v=%b cnt=%0d ovr=%b to=%b",
                 i, valid_o, count_o, overrun_o, timeout_o, mq.size() > 0, mq.size(), m_ovr, exp_to);
      end
      if (mq.size() > 0) begin
        n_checks++;
        if ({frame_error_o, parity_error_o, data_o} !== mq[0]) begin
          n_errors++;
          $display("FAIL rand%0d_head: got %b want %b", i,
                   {frame_error_o, parity_error_o, data_o}, mq[0]);
        end
      end
    end
    for (int i = 0; i < 40 && mq.size() > 0; i++) idle(1);
    tick(0, 0, 0, '0, 0, 1, 0);
    n_checks++;
    if (valid_o !== 1'b0 || overrun_o !== 1'b0) begin
      n_errors++; $display("FAIL rand_final: got v=%b ovr=%b want 0 0", valid_o, overrun_o);
    end
  endtask

`ifdef UART_RX_FIFO_TIMEOUT_EN
  task automatic test_timeout;
    tick(1, 0, 0, 8'h3C, 0, 0, 0);
    for (int k = 1; k <= TO_LIMIT + 20; k++) begin
      idle(0);
      n_checks++;
      if (timeout_o !== (k >= TO_LIMIT)) begin
        n_errors++; $display("FAIL to_first k=%0d: got %b want %b", k, timeout_o, k >= TO_LIMIT);
      end
    end
    tick(1, 0, 0, 8'h3D, 0, 0, 0);
    n_checks++;
    if (timeout_o !== 1'b0 || count_o !== PW'(2)) begin
      n_errors++; $display("FAIL to_drop: got to=%b cnt=%0d want to=0 cnt=2", timeout_o, count_o);
    end
    for (int k = 1; k <= TO_LIMIT + 5; k++) begin
      idle(0);
      n_checks++;
      if (timeout_o !== (k >= TO_LIMIT)) begin
        n_errors++; $display("FAIL to_second k=%0d: got %b want %b", k, timeout_o, k >= TO_LIMIT);
      end
    end
    idle(1);
    n_checks++;
    if (timeout_o !== 1'b0) begin n_errors++; $display("FAIL to_read_drop: got %b want 0", timeout_o); end
    idle(1);
    n_checks++;
    if (valid_o !== 1'b0 || timeout_o !== 1'b0) begin
      n_errors++; $display("FAIL to_empty: got v=%b to=%b want 0 0", valid_o, timeout_o);
    end
  endtask
`endif

  initial begin
    cyc = 0; last_evt = 0; m_ovr = 1'b0;
    rst = 1'b1; valid_i = 1'b0; frame_error_i = 1'b0; parity_error_i = 1'b0;
    char_i = '0; ready_i = 1'b0; clear_overrun_i = 1'b0;
    test_reset;
    test_single;
    test_flags;
    test_overrun;
    test_full_simul;
    test_wrap_random;
`ifdef UART_RX_FIFO_TIMEOUT_EN
    test_timeout;
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
